// File: rtl/gated_bitop_fifo_if.sv
// Producer/consumer handshake bundle for gated_bitop_fifo.
// The slave modport is the FIFO's view; master is the environment driving it.
interface gated_bitop_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_gate;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_gate, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_gate, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/gated_bitop_fifo.sv
// Gate-bit bitwise operator (AND/OR/XOR/PASS) feeding a DEPTH-entry FIFO,
// with a saturating count of accepted words.
module gated_bitop_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  gated_bitop_fifo_if.slave bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] acc_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef struct packed {
    logic             zero;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             live;   // holds in_ready low until the first edge after reset
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] gate;
  logic [WIDTH-1:0] result;

  // Ready depends on registered state only, so a pop never frees a slot in the same cycle.
  assign bus.in_ready  = live && (count < OCC_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr].data : '0;
  assign bus.out_zero  = bus.out_valid ? mem[rd_ptr].zero : 1'b0;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  assign gate = {WIDTH{bus.in_gate}};

  // NOTE: assign a default before the case so every path drives result; no latch is inferred.
  always_comb begin
    result = bus.in_data;
    unique case (op_e'(bus.in_op))
      OP_AND:  result = bus.in_data & gate;
      OP_OR:   result = bus.in_data | gate;
      OP_XOR:  result = bus.in_data ^ gate;
      OP_PASS: result = bus.in_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty count masks stale entries, keeping this a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{zero: (result == '0), data: result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (cnt_clr) begin
      acc_cnt <= '0;
    end else if (push && (acc_cnt != '1)) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gated_bitop_fifo.sv
// Randomised and directed bench for gated_bitop_fifo against a queue-based model.
module tb_gated_bitop_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int ACC_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] acc_cnt;

  gated_bitop_fifo_if #(.WIDTH(WIDTH)) bus ();

  gated_bitop_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .cnt_clr (cnt_clr),
    .acc_cnt (acc_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q[$];
  bit               live;
  int               acc;
  int               popped;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] bitop(input logic [WIDTH-1:0] d, input logic g,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return g ? d : '0;
      2'd1:    return g ? '1 : d;
      2'd2:    return g ? ~d : d;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    live = 1'b0;
    acc  = 0;
  endtask

  // Compare all outputs with the model, then advance one clock and update the model.
  task automatic step();
    logic [WIDTH-1:0] hd;
    logic [WIDTH-1:0] r;
    bit               m_push;
    bit               m_pop;
    hd = (q.size() != 0) ? q[0] : '0;
    check("in_ready",  64'(bus.in_ready),  64'(live && (q.size() < DEPTH)));
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check("out_data",  64'(bus.out_data),  64'(hd));
    check("out_zero",  64'(bus.out_zero),  64'((q.size() != 0) && (hd == '0)));
    check("acc_cnt",   64'(acc_cnt),       64'(acc));
    m_push = rst_n && bus.in_valid && live && (q.size() < DEPTH);
    m_pop  = rst_n && (q.size() != 0) && bus.out_ready;
    r      = bitop(bus.in_data, bus.in_gate, bus.in_op);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (m_push) q.push_back(r);
      if (cnt_clr) acc = 0;
      else if (m_push && acc < ACC_MAX) acc++;
      live = 1'b1;
    end
  endtask

  logic [WIDTH-1:0] op_exp  [5] = '{8'hA5, 8'hFF, 8'h5A, 8'hA5, 8'h00};
  logic [1:0]       op_tab  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic             gate_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int p0;
    int budget;
    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.in_gate   = 1'b0;
    bus.in_op     = 2'd0;
    bus.out_ready = 1'b0;
    popped        = 0;
    model_reset();
    #1;

    // Reset held with in_valid high, then release.
    repeat (3) step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step();
    check("ready_after_release", 64'(bus.in_ready), 64'd1);

    // Each op with data 0xA5, streaming so the head is the word just pushed.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'hA5;
      bus.in_gate = gate_tab[i];
      bus.in_op   = op_tab[i];
      step();
      check("op_result", 64'(bus.out_data), 64'(op_exp[i]));
    end
    check("op_zero_flag", 64'(bus.out_zero), 64'd1);
    bus.in_valid = 1'b0;
    step();

    // Fill to full with no consumer, offer a fifth word, then drain.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'd3;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = WIDTH'(i);
      step();
    end
    check("full_ready_low", 64'(bus.in_ready), 64'd0);
    bus.in_data = 8'h05;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("drain_head_first", 64'(bus.out_data), 64'h01);
    repeat (5) step();

    // Streaming: output is the input delayed by one cycle.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = WIDTH'(8'h10 + i);
      step();
      check("stream_delay", 64'(bus.out_data), 64'(8'h10 + i));
    end
    bus.in_valid = 1'b0;
    step();

    // Back-pressure: out_ready toggles every cycle until 32 words are popped.
    p0     = popped;
    budget = 0;
    while ((popped - p0) < 32 && budget < 400) begin
      bus.out_ready = ~bus.out_ready;
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.in_data   = WIDTH'($urandom);
      bus.in_gate   = 1'($urandom);
      bus.in_op     = 2'($urandom);
      step();
      budget++;
    end
    check("bp_popped_32", 64'((popped - p0) >= 32), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 1) step();

    // Counter saturation, then clear colliding with a push.
    cnt_clr = 1'b1;
    step();
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b1;
    repeat (17) step();
    check("acc_saturated", 64'(acc_cnt), 64'(ACC_MAX));
    cnt_clr = 1'b1;
    step();
    check("acc_clr_over_push", 64'(acc_cnt), 64'd0);
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b0;
    step();

    // Asynchronous reset with three words queued.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) step();
    bus.in_valid = 1'b0;
    check("three_queued", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_acc", 64'(acc_cnt), 64'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Random traffic with occasional counter clears.
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.in_data   = WIDTH'($urandom);
      bus.in_gate   = 1'($urandom);
      bus.in_op     = 2'($urandom);
      cnt_clr       = 1'($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
